// File: rtl/pb_pkg.sv
// Shared types and constants for the pushbutton increment controller.
package pb_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    REL      = 2'd0,
    PRS_WAIT = 2'd1,
    PRS      = 2'd2,
    REL_WAIT = 2'd3
  } pb_state_t;

  // End points of the 4-bit downstream counter.
  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] CNT_MIN = 4'h0;

  // Debounced level seen by the outside world: released until a press is accepted.
  function automatic logic is_released(input pb_state_t s);
    return (s == REL) || (s == PRS_WAIT);
  endfunction

endpackage

// File: rtl/pb_inc_ctrl_if.sv
// Button-side and counter-side signals of the increment controller.
interface pb_inc_ctrl_if;
  logic pb_n;   // raw pushbutton, 0 = pressed
  logic en;     // one-cycle counter enable per accepted release
  logic dwn;    // counter direction, 1 = down
  logic pb_db;  // debounced level, 1 = released

  modport master (output pb_n, input en, input dwn, input pb_db);
  modport slave  (input pb_n, output en, output dwn, output pb_db);
endinterface

// File: rtl/pb_sync2.sv
// Two-flop synchronizer for the raw pushbutton; resets to the released level.
module pb_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values of the synchronizer chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, preset to 1 so reset looks like a released button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pb_inc_ctrl.sv
// Pushbutton debouncer producing a counter enable on each accepted release,
// plus a ping-pong up/down direction for a 4-bit downstream counter.
// Build option: define PB_INC_DIR_EN to include the shadow count and the
// direction logic; without it dwn is tied to 0 and the counter simply wraps.
module pb_inc_ctrl
  import pb_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned DB_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pb_inc_ctrl_if.slave  bus
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            pb_s;
  pb_state_t       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            pb_db_q, pb_db_d;

  pb_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pb_n),
    .q     (pb_s)
  );

  // Debounce next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    unique case (state_q)
      REL: begin
        if (!pb_s) begin
          state_d = PRS_WAIT;
          cnt_d   = '0;
        end
      end
      PRS_WAIT: begin
        if (pb_s)                  state_d = REL;
        else if (cnt_q == DB_LAST) state_d = PRS;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      PRS: begin
        if (pb_s) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (!pb_s) begin
          state_d = PRS;
        end else if (cnt_q == DB_LAST) begin
          state_d = REL;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = REL;
    endcase
    // Decoded from the next state so pb_db lines up with the FSM state.
    pb_db_d = is_released(state_d);
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REL;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      pb_db_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      pb_db_q <= pb_db_d;
    end
  end

  assign bus.en    = en_q;
  assign bus.pb_db = pb_db_q;

`ifdef PB_INC_DIR_EN
  logic [3:0] shadow_q, shadow_d;
  logic       dwn_q, dwn_d;

  // Shadow of the downstream counter; direction flips as it reaches an end point,
  // so dwn only moves on the edge that consumes an en pulse.
  always_comb begin
    shadow_d = shadow_q;
    dwn_d    = dwn_q;
    if (en_q) begin
      if (!dwn_q) begin
        shadow_d = shadow_q + 4'd1;
        if (shadow_q == CNT_MAX - 4'd1) dwn_d = 1'b1;
      end else begin
        shadow_d = shadow_q - 4'd1;
        if (shadow_q == CNT_MIN + 4'd1) dwn_d = 1'b0;
      end
    end
  end

  // Shadow count and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= CNT_MIN;
      dwn_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      dwn_q    <= dwn_d;
    end
  end

  assign bus.dwn = dwn_q;
`else
  assign bus.dwn = 1'b0;
`endif

endmodule

// File: doc/pb_inc_ctrl.md
PB_INC_CTRL -- requirements
Module: pb_inc_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16'd50000: number of consecutive clocks a synchronized level change must hold before it is accepted.
REQ-002 Parameter DB_W, default 16: width of the debounce counter; DB_CYCLES SHALL be at least 1 and at most 2**DB_W-1.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pb_n  input  1  raw asynchronous pushbutton; 0 = pressed, 1 = released.
REQ-006 en  output  1  registered one-cycle pulse on each accepted release; feeds the downstream counter enable.
REQ-007 dwn  output  1  registered count direction for the downstream counter; 0 = up, 1 = down.
REQ-008 pb_db  output  1  registered debounced button level; 1 = released.

Function
REQ-009 pb_n SHALL pass through a two-flop synchronizer; no other logic reads pb_n directly.
REQ-010 Debounce FSM states SHALL be REL, PRS_WAIT, PRS, REL_WAIT.
REQ-011 REL: a synchronized 0 enters PRS_WAIT and clears the debounce counter.
REQ-012 PRS_WAIT: counter increments each clock while sync = 0; sync = 1 returns to REL; counter = DB_CYCLES-1 enters PRS.
REQ-013 PRS: a synchronized 1 enters REL_WAIT and clears the counter.
REQ-014 REL_WAIT: counter increments while sync = 1; sync = 0 returns to PRS; counter = DB_CYCLES-1 enters REL and asserts en for exactly one cycle.
REQ-015 en latency SHALL be exactly DB_CYCLES+3 clocks from the first rising edge that samples pb_n = 1 (bounce-free release).
REQ-016 pb_db SHALL be 1 in REL and PRS_WAIT, and 0 in PRS and REL_WAIT.
REQ-017 A press never asserts en; en is never high on two consecutive cycles.
REQ-018 A 4-bit shadow count SHALL mirror the downstream counter: +1 on en when dwn = 0, -1 on en when dwn = 1, with modulo-16 arithmetic.
REQ-019 On an en cycle with dwn = 0 and shadow = 14, dwn SHALL become 1 at the same edge that the shadow becomes 15.
REQ-020 On an en cycle with dwn = 1 and shadow = 1, dwn SHALL become 0 at the same edge that the shadow becomes 0.
REQ-021 dwn SHALL change only at an edge where en = 1, so it is stable for the entire cycle of every en pulse.

Reset
REQ-022 While rst_n = 0: synchronizer flops = 1, FSM = REL, debounce counter = 0, en = 0, dwn = 0, pb_db = 1, shadow = 0.
REQ-023 Reset asserted mid-debounce SHALL abort the debounce without generating en; after release of reset the button is treated as released.

Configuration
REQ-024 Macro PB_INC_DIR_EN defined: the shadow count and ping-pong direction logic (REQ-018 to REQ-021) are present.
REQ-025 PB_INC_DIR_EN undefined: the shadow count is not built, dwn is held at constant 0, and the downstream counter wraps from 15 to 0.

Structure
REQ-026 Shared package pb_pkg SHALL hold the FSM state enum (pb_state_t) and the constants CNT_MAX = 4'hF and CNT_MIN = 4'h0.
REQ-027 Sub-module pb_sync2 SHALL implement the two-flop synchronizer; all other logic stays in pb_inc_ctrl.

Verification
REQ-028 DB_CYCLES=4; press pb_n=0 for 10 clocks, release -> single en pulse exactly 7 clocks after the first high sample; pb_db follows the FSM.
REQ-029 DB_CYCLES=4; release with pb_n toggling 1/0/1/0 every clock for 6 clocks, then stable 1 -> exactly one en, timed from the start of the final stable high.
REQ-030 PB_INC_DIR_EN defined; 15 clean press/release cycles -> dwn rises at the 15th en edge; the 16th en decrements (shadow 14); after the 30th en, shadow = 0 and dwn = 0.
REQ-031 PB_INC_DIR_EN undefined; 17 clean press/release cycles -> 17 en pulses; dwn = 0 throughout.
REQ-032 Deassert rst_n mid-REL_WAIT (counter = 2) -> en never asserts, all outputs take their reset values asynchronously, and the next clean release produces a normal en.
REQ-033 Hold pb_n = 0 for 1000 clocks -> en = 0 throughout and pb_db = 0 after DB_CYCLES+3 clocks.
